// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory subsystem: arbiter FSM states, port owner
// encoding and the latched memory request record.
package rv32i_types;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        IMEM_BUSY,
        DMEM_BUSY
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IMEM,
        OWNER_DMEM
    } mem_arb_owner_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_MASK_W-1:0] rmask;
        logic [MEM_MASK_W-1:0] wmask;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic mem_arb_owner_t owner_of(input mem_arb_state_t s);
        case (s)
            IMEM_BUSY: return OWNER_IMEM;
            DMEM_BUSY: return OWNER_DMEM;
            default:   return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of data grants that bypassed a waiting fetch; at_limit
// tells the arbiter to hand the next grant to the fetch channel.
module arb_starve_counter #(
    parameter int LIMIT = 4,
    localparam int W = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_limit
);

    assign at_limit = (count == W'(LIMIT));

    // Clear wins over increment; increment stops at LIMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between fetch and data channels: data has
// priority, the starvation counter forces a fetch grant after STARVE_LIMIT bypasses.
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_ADDR_W-1:0] imem_addr,
    input  logic [MEM_MASK_W-1:0] imem_rmask,
    output logic [MEM_DATA_W-1:0] imem_rdata,
    output logic                  imem_resp,
    input  logic [MEM_ADDR_W-1:0] dmem_addr,
    input  logic [MEM_MASK_W-1:0] dmem_rmask,
    input  logic [MEM_MASK_W-1:0] dmem_wmask,
    input  logic [MEM_DATA_W-1:0] dmem_wdata,
    output logic [MEM_DATA_W-1:0] dmem_rdata,
    output logic                  dmem_resp,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_MASK_W-1:0] mem_rmask,
    output logic [MEM_MASK_W-1:0] mem_wmask,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    mem_arb_state_t state, state_next;
    mem_arb_owner_t owner;
    mem_req_t       port_q, port_d;

    logic             imem_req, dmem_req, dmem_store, imem_forced;
    logic             cnt_inc, cnt_clr, at_limit;
    logic [CNT_W-1:0] starve_cnt;

    assign imem_req    = |imem_rmask;
    assign dmem_store  = |dmem_wmask;
    assign dmem_req    = dmem_store || (|dmem_rmask);
    assign imem_forced = imem_req && at_limit;

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .count   (starve_cnt),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            port_q <= '0;
        end else begin
            state  <= state_next;
            port_q <= port_d;
        end
    end

    always_comb begin
        state_next = state;
        port_d     = port_q;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dmem_req && !imem_forced) begin
                    // A store suppresses the read mask even if the requester set both.
                    port_d.addr  = dmem_addr;
                    port_d.rmask = dmem_store ? '0 : dmem_rmask;
                    port_d.wmask = dmem_wmask;
                    port_d.wdata = dmem_wdata;
                    cnt_inc      = imem_req;
                    state_next   = DMEM_BUSY;
                end else if (imem_req) begin
                    port_d.addr  = imem_addr;
                    port_d.rmask = imem_rmask;
                    port_d.wmask = '0;
                    port_d.wdata = '0;
                    cnt_clr      = 1'b1;
                    state_next   = IMEM_BUSY;
                end else begin
                    port_d.rmask = '0;
                    port_d.wmask = '0;
                end
            end
            IMEM_BUSY, DMEM_BUSY: begin
                // The latched request is held regardless of requester-side changes.
                if (mem_resp) begin
                    port_d.rmask = '0;
                    port_d.wmask = '0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Responses are combinational and only reach the channel owning the port.
    assign owner      = owner_of(state);
    assign imem_resp  = mem_resp && (owner == OWNER_IMEM);
    assign dmem_resp  = mem_resp && (owner == OWNER_DMEM);
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    assign mem_addr  = port_q.addr;
    assign mem_rmask = port_q.rmask;
    assign mem_wmask = port_q.wmask;
    assign mem_wdata = port_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable memory, a
// transaction-level reference model checked every cycle, and literal checks.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata),
        .imem_resp (imem_resp),
        .dmem_addr (dmem_addr),
        .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_resp (dmem_resp),
        .mem_addr  (mem_addr),
        .mem_rmask (mem_rmask),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got '%s', required '%s'", name, act, exp);
        end
    endtask

    // Memory: responds lat cycles after a request first appears on the port.
    int lat;
    bit pend;
    int wcnt;
    bit inject;

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a == 32'h6000_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        pend      = 1'b0;
        wcnt      = 0;
        inject    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                mem_resp = 1'b0;
                pend     = 1'b0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
                pend     = 1'b0;
            end else if (inject) begin
                mem_resp  = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                inject    = 1'b0;
            end else if (pend) begin
                wcnt++;
                if (wcnt >= lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rd_data(mem_addr);
                end
            end else if ((mem_rmask | mem_wmask) != 4'h0) begin
                pend = 1'b1;
                wcnt = 0;
            end
        end
    end

    // Reference model: who owns the port, what request is latched, how many
    // data grants have bypassed a waiting fetch.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
    } tx_t;

    int    m_owner;   // 0 none, 1 imem, 2 dmem
    tx_t   m_tx;
    int    m_starve;
    string m_log;
    bit    m_ip, m_dp;

    initial begin
        m_owner  = 0;
        m_tx     = '0;
        m_starve = 0;
        m_log    = "";
        forever begin
            @(posedge clk or negedge rst);
            m_ip = (imem_rmask != 4'h0);
            m_dp = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
            if (!rst) begin
                m_owner  = 0;
                m_tx     = '0;
                m_starve = 0;
            end else if (m_owner == 0) begin
                if (m_dp && !(m_ip && m_starve == LIMIT)) begin
                    m_tx.addr = dmem_addr;
                    m_tx.wm   = dmem_wmask;
                    m_tx.rm   = (dmem_wmask != 4'h0) ? 4'h0 : dmem_rmask;
                    m_tx.wd   = dmem_wdata;
                    m_owner   = 2;
                    if (m_ip && m_starve < LIMIT) m_starve++;
                    m_log = {m_log, "D"};
                end else if (m_ip) begin
                    m_tx.addr = imem_addr;
                    m_tx.rm   = imem_rmask;
                    m_tx.wm   = 4'h0;
                    m_tx.wd   = 32'h0;
                    m_owner   = 1;
                    m_starve  = 0;
                    m_log = {m_log, "I"};
                end else begin
                    m_tx.rm = 4'h0;
                    m_tx.wm = 4'h0;
                end
            end else if (mem_resp) begin
                m_tx.rm = 4'h0;
                m_tx.wm = 4'h0;
                m_owner = 0;
            end
        end
    end

    // Every-cycle comparison against the model, plus a log of observed responses.
    string d_log;

    initial begin
        d_log = "";
        forever begin
            @(negedge clk);
            chk("mem_addr", mem_addr, m_tx.addr);
            chk("mem_rmask", 32'(mem_rmask), 32'(m_tx.rm));
            chk("mem_wmask", 32'(mem_wmask), 32'(m_tx.wm));
            chk("mem_wdata", mem_wdata, m_tx.wd);
            chk("imem_resp", 32'(imem_resp), 32'(rst && m_owner == 1 && mem_resp));
            chk("dmem_resp", 32'(dmem_resp), 32'(rst && m_owner == 2 && mem_resp));
            if (imem_resp) begin
                chk("imem_rdata", imem_rdata, mem_rdata);
                d_log = {d_log, "I"};
            end
            if (dmem_resp) begin
                chk("dmem_rdata", dmem_rdata, mem_rdata);
                d_log = {d_log, "D"};
            end
        end
    end

    task automatic wait_resp(input bit is_imem, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            n++;
            if (is_imem ? imem_resp : dmem_resp) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: got no %s response, required one within 30 cycles",
                     is_imem ? "imem" : "dmem");
        end
    endtask

    int  n;
    int  nd;
    bit  drop_i, drop_d;

    initial begin
        rst        = 1'b0;
        imem_addr  = '0;
        imem_rmask = '0;
        dmem_addr  = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        lat        = 1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Idle after reset: port quiet, no responses.
        repeat (10) begin
            @(negedge clk);
            chk("idle_masks", 32'(mem_rmask | mem_wmask), 32'h0);
            chk("idle_resps", 32'({imem_resp, dmem_resp}), 32'h0);
        end
        chk("idle_addr", mem_addr, 32'h0);

        // Fetch only, memory latency 3.
        @(posedge clk); #1;
        lat        = 3;
        imem_addr  = 32'h6000_0000;
        imem_rmask = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("fetch_addr", mem_addr, 32'h6000_0000);
        chk("fetch_rmask", 32'(mem_rmask), 32'hF);
        wait_resp(1'b1, n);
        chk("fetch_latency", n, 3);
        chk("fetch_rdata", imem_rdata, 32'h0000_0013);
        chk("fetch_no_dresp", 32'(dmem_resp), 32'h0);
        @(posedge clk); #1;
        imem_rmask = '0;

        // Simultaneous fetch and store: store first, then fetch.
        lat        = 1;
        imem_addr  = 32'h6000_0004;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h0000_1000;
        dmem_wmask = 4'h3;
        dmem_wdata = 32'h0000_BEEF;
        @(negedge clk);
        @(negedge clk);
        chk("both_addr", mem_addr, 32'h0000_1000);
        chk("both_wmask", 32'(mem_wmask), 32'h3);
        chk("both_rmask", 32'(mem_rmask), 32'h0);
        chk("both_wdata", mem_wdata, 32'h0000_BEEF);
        wait_resp(1'b0, n);
        chk("store_latency", n, 1);
        @(posedge clk); #1;
        dmem_wmask = '0;
        @(negedge clk);
        @(negedge clk);
        chk("next_fetch_addr", mem_addr, 32'h6000_0004);
        chk("next_fetch_rmask", 32'(mem_rmask), 32'hF);
        chk("next_fetch_wmask", 32'(mem_wmask), 32'h0);
        chk("next_fetch_wdata", mem_wdata, 32'h0);
        wait_resp(1'b1, n);
        chk("next_fetch_latency", n, 1);
        @(posedge clk); #1;
        imem_rmask = '0;
        chk_s("order_dut_a", d_log, "IDI");
        chk_s("order_model_a", m_log, "IDI");

        // Starvation: continuous loads with a fetch pending.
        d_log      = "";
        m_log      = "";
        nd         = 0;
        drop_i     = 1'b0;
        drop_d     = 1'b0;
        imem_addr  = 32'h6000_0008;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h0000_2100;
        dmem_rmask = 4'hF;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (imem_resp) begin
                chk("starve_cnt_after_fetch", 32'(u_dut.starve_cnt), 32'h0);
                drop_i = 1'b1;
            end
            if (dmem_resp) nd++;
            if (nd == 5) drop_d = 1'b1;
            @(posedge clk); #1;
            if (drop_i) imem_rmask = '0;
            if (drop_d) begin
                dmem_rmask = '0;
                break;
            end
        end
        chk("starve_done", 32'(drop_d), 32'h1);
        chk_s("order_dut_starve", d_log, "DDDDID");
        chk_s("order_model_starve", m_log, "DDDDID");

        // Store and load masks together: write wins, read mask cleared.
        lat        = 2;
        dmem_addr  = 32'h0000_4000;
        dmem_rmask = 4'hF;
        dmem_wmask = 4'h1;
        dmem_wdata = 32'h1122_3344;
        @(negedge clk);
        @(negedge clk);
        chk("rw_addr", mem_addr, 32'h0000_4000);
        chk("rw_wmask", 32'(mem_wmask), 32'h1);
        chk("rw_rmask", 32'(mem_rmask), 32'h0);
        chk("rw_wdata", mem_wdata, 32'h1122_3344);
        wait_resp(1'b0, n);
        chk("rw_latency", n, 2);
        @(posedge clk); #1;
        dmem_rmask = '0;
        dmem_wmask = '0;

        // Requester address change during the transaction is ignored.
        lat        = 4;
        dmem_addr  = 32'h0000_2000;
        dmem_rmask = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("hold_addr_start", mem_addr, 32'h0000_2000);
        @(posedge clk); #1;
        dmem_addr = 32'h0000_3000;
        wait_resp(1'b0, n);
        chk("hold_latency", n, 4);
        chk("hold_addr_resp", mem_addr, 32'h0000_2000);
        chk("hold_rdata", dmem_rdata, 32'h5A5A_2000);
        chk("hold_no_iresp", 32'(imem_resp), 32'h0);
        @(posedge clk); #1;
        dmem_rmask = '0;

        // Async reset in the middle of a load.
        lat        = 5;
        dmem_addr  = 32'h0000_5000;
        dmem_rmask = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_rmask", 32'(mem_rmask), 32'hF);
        #2;
        rst        = 1'b0;
        dmem_rmask = '0;
        #1;
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rmask", 32'(mem_rmask), 32'h0);
        chk("rst_wmask", 32'(mem_wmask), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_starve", 32'(u_dut.starve_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        chk("stray_resp_seen", 32'(mem_resp), 32'h1);
        chk("stray_resp_ignored", 32'({imem_resp, dmem_resp}), 32'h0);
        chk("stray_masks", 32'(mem_rmask | mem_wmask), 32'h0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
